// File: rtl/mario_vertical_mover.sv
// rtl/mario_vertical_mover.sv - jump/fall FSM for Mario's vertical position with tile collision
// Optional MARIO_VARIABLE_JUMP_EN: releasing jump while rising cuts the jump short.
module mario_vertical_mover #(
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int START_Y         = 398,
  parameter int JUMP_HEIGHT     = 80
) (
  input  logic                      movement_clock,
  input  logic                      reset,
  input  logic                      jump_i,
  input  logic [11:0][16:0][7:0]    background_i,
  input  logic signed [31:0]        mario_x_i,
  output logic signed [31:0]        mario_y_o,
  output logic                      airborne_o
);

  localparam logic [7:0] BLK  = 8'd2;
  localparam logic [7:0] GND  = 8'd3;
  localparam int         COLS = 17;
  localparam int         CW   = $clog2(JUMP_HEIGHT + 1);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] y_q, y_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               jump_prev_q;

  logic signed [31:0] x_r;
  logic               col_ok_l, col_ok_r;
  logic [4:0]         col_l, col_r;
  logic [3:0]         row_above, row_below;
  logic               above_ok, below_ok;
  logic               blocked_above, supported;
  logic               jump_req, rise_cut;

  function automatic logic is_solid(input logic [7:0] t);
    return (t == BLK) || (t == GND);
  endfunction

  assign x_r       = mario_x_i + CHARACTER_WIDTH - 1;
  assign col_ok_l  = (mario_x_i >= 0) && (mario_x_i < COLS * BLOCK_WIDTH);
  assign col_ok_r  = (x_r >= 0) && (x_r < COLS * BLOCK_WIDTH);
  assign col_l     = 5'(mario_x_i / BLOCK_WIDTH);
  assign col_r     = 5'(x_r / BLOCK_WIDTH);
  assign row_above = 4'((y_q - 1) / BLOCK_WIDTH);
  assign row_below = 4'((y_q + CHARACTER_WIDTH) / BLOCK_WIDTH);
  assign above_ok  = (y_q > 0);
  assign below_ok  = (y_q + CHARACTER_WIDTH < SCREEN_HEIGHT);

  // Map reads are gated by the range checks so out-of-range indices never matter.
  always_comb begin
    blocked_above = (y_q == 0);
    supported     = !below_ok;
    if (above_ok && col_ok_l && is_solid(background_i[row_above][col_l])) blocked_above = 1'b1;
    if (above_ok && col_ok_r && is_solid(background_i[row_above][col_r])) blocked_above = 1'b1;
    if (below_ok && col_ok_l && is_solid(background_i[row_below][col_l])) supported = 1'b1;
    if (below_ok && col_ok_r && is_solid(background_i[row_below][col_r])) supported = 1'b1;
  end

  assign jump_req = jump_i && !jump_prev_q;

`ifdef MARIO_VARIABLE_JUMP_EN
  assign rise_cut = !jump_i;
`else
  assign rise_cut = 1'b0;
`endif

  always_ff @(posedge movement_clock) begin
    if (reset) begin
      state_q     <= GROUNDED;
      y_q         <= START_Y;
      cnt_q       <= '0;
      jump_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      jump_prev_q <= jump_i;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GROUNDED: begin
        if (!supported) begin
          state_d = FALLING;
          y_d     = y_q + 1;
        end else if (jump_req && !blocked_above) begin
          state_d = RISING;
          y_d     = y_q - 1;
          cnt_d   = CW'(1);
        end
      end
      RISING: begin
        if (blocked_above || rise_cut || (cnt_q == CW'(JUMP_HEIGHT))) begin
          state_d = FALLING;
        end else begin
          y_d   = y_q - 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      FALLING: begin
        if (supported) state_d = GROUNDED;
        else           y_d     = y_q + 1;
      end
      default: state_d = GROUNDED;
    endcase
  end

  always_comb begin
    mario_y_o  = y_q;
    airborne_o = (state_q != GROUNDED);
  end

endmodule

// File: tb/tb_mario_vertical_mover.sv
// tb/tb_mario_vertical_mover.sv - directed bench with pixel-level behavioural model of the vertical mover
module tb_mario_vertical_mover;

  logic                   clk;
  logic                   reset;
  logic                   jump;
  logic [11:0][16:0][7:0] bg;
  logic signed [31:0]     mario_x;
  logic signed [31:0]     mario_y;
  logic                   airborne;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 0;

  // Model state: position, airborne/rising flags, pixels risen so far, previous button.
  int m_y;
  bit m_air, m_up, m_jprev;
  int m_risen;

  mario_vertical_mover dut (
    .movement_clock (clk),
    .reset          (reset),
    .jump_i         (jump),
    .background_i   (bg),
    .mario_x_i      (mario_x),
    .mario_y_o      (mario_y),
    .airborne_o     (airborne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit solid_px(int px, int py);
    logic [7:0] t;
    if (px < 0 || py < 0 || px >= 680 || py >= 480) return 1'b0;
    t = bg[py / 40][px / 40];
    return (t == 8'd2) || (t == 8'd3);
  endfunction

  always @(posedge clk) begin
    int  lft, rgt, ny, nr;
    bit  top_hit, floor_hit, press, nair, nup, cut;
    if (reset) begin
      m_y <= 398; m_air <= 0; m_up <= 0; m_risen <= 0; m_jprev <= 1;
    end else begin
      lft = mario_x; rgt = mario_x + 41;
      top_hit   = (m_y == 0) || solid_px(lft, m_y - 1) || solid_px(rgt, m_y - 1);
      floor_hit = (m_y + 42 >= 480) || solid_px(lft, m_y + 42) || solid_px(rgt, m_y + 42);
      press = jump && !m_jprev;
`ifdef MARIO_VARIABLE_JUMP_EN
      cut = !jump;
`else
      cut = 0;
`endif
      ny = m_y; nair = m_air; nup = m_up; nr = m_risen;
      if (!m_air) begin
        if (!floor_hit) begin nair = 1; nup = 0; ny = m_y + 1; end
        else if (press && !top_hit) begin nair = 1; nup = 1; ny = m_y - 1; nr = 1; end
      end else if (m_up) begin
        if (top_hit || cut || m_risen == 80) nup = 0;
        else begin ny = m_y - 1; nr = m_risen + 1; end
      end else begin
        if (floor_hit) nair = 0;
        else ny = m_y + 1;
      end
      m_y <= ny; m_air <= nair; m_up <= nup; m_risen <= nr; m_jprev <= jump;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (mario_y !== m_y) begin
        n_miss++;
        $display("FAIL model_y t=%0t: got %0d expected %0d", $time, mario_y, m_y);
      end
      n_vec++;
      if (airborne !== m_air) begin
        n_miss++;
        $display("FAIL model_airborne t=%0t: got %0d expected %0d", $time, airborne, m_air);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    int apex_exp;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        bg[r][c] = (r == 11) ? 8'd3 : 8'd1;
    reset = 1; jump = 1; mario_x = 100;
    step(2);
    chk("reset_y", mario_y, 398);
    chk("reset_air", airborne, 0);
    cmp_en = 1;
    reset = 0;
    step(5);
    chk("held_no_jump_y", mario_y, 398);
    chk("held_no_jump_air", airborne, 0);

    // Full jump on open sky, button held through landing.
    jump = 0; step(2);
    jump = 1; step(1);
    chk("first_rise_y", mario_y, 397);
    chk("first_rise_air", airborne, 1);
    step(79);
    chk("top_y", mario_y, 318);
    step(1);
    chk("apex_y", mario_y, 318);
    chk("apex_air", airborne, 1);
    step(80);
    chk("fall_end_y", mario_y, 398);
    chk("fall_end_air", airborne, 1);
    step(1);
    chk("landed_air", airborne, 0);
    step(3);
    chk("no_retrigger_y", mario_y, 398);
    jump = 0; step(1);

    // Brick overhead at row 8, col 2.
    bg[8][2] = 8'd2;
    jump = 1; step(38);
    chk("bonk_y", mario_y, 360);
    step(1);
    chk("bonk_hold_y", mario_y, 360);
    chk("bonk_air", airborne, 1);
    jump = 0; step(38);
    chk("bonk_back_y", mario_y, 398);
    step(1);
    chk("bonk_land_air", airborne, 0);
    bg[8][2] = 8'd1;

    // Remove floor under cols 2-3: fall to screen bottom.
    bg[11][2] = 8'd1; bg[11][3] = 8'd1;
    step(1);
    chk("drop_y", mario_y, 399);
    chk("drop_air", airborne, 1);
    step(39);
    chk("bottom_y", mario_y, 438);
    step(1);
    chk("bottom_air", airborne, 0);
    bg[11][2] = 8'd3; bg[11][3] = 8'd3;
    reset = 1; step(1);
    chk("rereset_y", mario_y, 398);
    reset = 0; step(1);

    // Early release at edge 10.
    jump = 1; step(1);
    step(9);
    chk("pre_release_y", mario_y, 388);
    jump = 0; step(1);
`ifdef MARIO_VARIABLE_JUMP_EN
    apex_exp = 388;
`else
    apex_exp = 387;
`endif
    chk("release_y", mario_y, apex_exp);
    step(200);
    chk("release_land_y", mario_y, 398);
    chk("release_land_air", airborne, 0);

    // Reset while rising.
    jump = 1; step(48);
    chk("mid_rise_y", mario_y, 350);
    reset = 1; step(1);
    chk("mid_reset_y", mario_y, 398);
    chk("mid_reset_air", airborne, 0);
    reset = 0; jump = 0; step(1);
    jump = 1; step(80);
    chk("after_reset_top_y", mario_y, 318);
    step(1);
    jump = 0; step(100);
    chk("after_reset_land_air", airborne, 0);

    // Column edge cases: right span off-map, then left edge negative.
    mario_x = 660; step(3);
    jump = 1; step(5);
    mario_x = 600; step(3);
    jump = 0; step(100);
    mario_x = -20; step(3);
    jump = 1; step(20);
    jump = 0; step(100);
    chk("edge_land_y", mario_y, 398);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
